// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter and sequencer for an 8:1 bit mux: grants one of 8 requesters,
// caps each grant at HOLD_MAX transfers and registers the selected data bit.
module mux_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] I,
  output logic [2:0] s,
  output logic [7:0] gnt,
  output logic       busy,
  output logic       y,
  output logic       y_vld
);

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

  localparam logic [3:0] LP_CNT_LAST = 4'(HOLD_MAX - 1);

  state_t     r_state;
  logic [2:0] r_ptr;
  logic [2:0] r_s;
  logic [3:0] r_cnt;
  logic [7:0] r_gnt;
  logic       r_y;
  logic       r_y_vld;

  logic [2:0] w_base;
  logic [2:0] w_win;
  logic       w_found;
  logic       w_xfer;
  logic       w_release;

  // One priority scan serves both idle arbitration (from ptr) and the same-edge
  // re-arbitration on release (from s+1, which is the ptr value being written).
  always_comb begin
    w_xfer    = (r_state == ST_GRANT) && req[r_s];
    w_release = (r_state == ST_GRANT) && (!w_xfer || (r_cnt == LP_CNT_LAST));
    w_base    = (r_state == ST_GRANT) ? r_s + 3'd1 : r_ptr;
    w_found   = 1'b0;
    w_win     = w_base;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!w_found && req[w_base + 3'(i)]) begin
        w_found = 1'b1;
        w_win   = w_base + 3'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_s     <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_y     <= 1'b0;
      r_y_vld <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_y_vld <= 1'b0;
          if (w_found) begin
            r_s     <= w_win;
            r_gnt   <= 8'd1 << w_win;
            r_cnt   <= '0;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          r_y_vld <= w_xfer;
          if (w_xfer) begin
            r_y <= I[r_s];
          end
          if (w_release) begin
            r_ptr <= r_s + 3'd1;
            if (w_found) begin
              r_s   <= w_win;
              r_gnt <= 8'd1 << w_win;
              r_cnt <= '0;
            end else begin
              r_gnt   <= '0;
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s     = r_s;
  assign gnt   = r_gnt;
  assign busy  = |r_gnt;
  assign y     = r_y;
  assign y_vld = r_y_vld;

endmodule
